// File: rtl/vga_mem_arbiter.sv
// Single-port tile-memory arbiter between the display fetch engine and the CPU.
// Display normally has priority. A CPU that has been denied STARVE_LIMIT times in a
// row overrides the display, and the display request it displaces is reported as a miss.
// Memory access pipeline: decide in N, drive mem_* in N+1, read data returns in N+2.

module vga_mem_arbiter #(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned DATA_W       = 9,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   // display fetch port
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   // cpu port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              disp_miss,
   input  logic              clear_miss
);

   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_RD   = 2'd1,
      C_ACK  = 2'd2
   } cpu_state_e;

   cpu_state_e        cpu_state_q, cpu_state_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              miss_q, miss_d;
   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              disp_p1_q, disp_p2_q;
   logic              ack_rd_q;

   logic              cpu_elig;
   logic              starved;
   logic              grant_disp;
   logic              grant_cpu;
   logic              drop;

   assign cpu_elig = cpu_req && (cpu_state_q == C_IDLE);
   assign starved  = (starve_q == STARVE_MAX);

   // Arbitration: display first unless the CPU has hit the starvation limit.
   always_comb begin
      grant_disp = 1'b0;
      grant_cpu  = 1'b0;
      drop       = 1'b0;
      if (disp_req && cpu_elig) begin
         if (starved) begin
            grant_cpu = 1'b1;
            drop      = 1'b1;
         end else begin
            grant_disp = 1'b1;
         end
      end else if (disp_req) begin
         grant_disp = 1'b1;
      end else if (cpu_elig) begin
         grant_cpu = 1'b1;
      end
   end

   // Starvation counter, miss flag and registered memory command.
   always_comb begin
      starve_d    = starve_q;
      miss_d      = miss_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (grant_cpu) begin
         starve_d = '0;
      end else if (cpu_elig && !starved) begin
         starve_d = starve_q + 1'b1;
      end

      // A drop in the same cycle as clear_miss leaves the flag set.
      if (drop) begin
         miss_d = 1'b1;
      end else if (clear_miss) begin
         miss_d = 1'b0;
      end

      // Address/data hold their value when idle to avoid needless toggling.
      if (grant_cpu) begin
         mem_addr_d = cpu_addr;
         if (cpu_we) begin
            mem_wdata_d = cpu_wdata;
         end
      end else if (grant_disp) begin
         mem_addr_d = disp_addr;
      end
   end

   // CPU FSM next state: reads wait one cycle for data, writes ack immediately.
   always_comb begin
      cpu_state_d = cpu_state_q;
      unique case (cpu_state_q)
         C_IDLE: begin
            if (grant_cpu) begin
               cpu_state_d = cpu_we ? C_ACK : C_RD;
            end
         end
         C_RD:    cpu_state_d = C_ACK;
         C_ACK:   cpu_state_d = C_IDLE;
         default: cpu_state_d = C_IDLE;
      endcase
   end

   // State registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_state_q <= C_IDLE;
         starve_q    <= '0;
         miss_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         disp_p1_q   <= 1'b0;
         disp_p2_q   <= 1'b0;
         ack_rd_q    <= 1'b0;
      end else begin
         cpu_state_q <= cpu_state_d;
         starve_q    <= starve_d;
         miss_q      <= miss_d;
         mem_en_q    <= grant_disp | grant_cpu;
         mem_we_q    <= grant_cpu & cpu_we;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         disp_p1_q   <= grant_disp;
         disp_p2_q   <= disp_p1_q;
         ack_rd_q    <= (cpu_state_q == C_RD);
      end
   end

   // Outputs are forced low while reset is held so in-flight pulses never escape.
   always_comb begin
      mem_en      = mem_en_q & ~reset;
      mem_we      = mem_we_q & ~reset;
      mem_addr    = reset ? '0 : mem_addr_q;
      mem_wdata   = reset ? '0 : mem_wdata_q;
      disp_rvalid = disp_p2_q & ~reset;
      disp_rdata  = disp_rvalid ? mem_rdata : '0;
      cpu_ack     = (cpu_state_q == C_ACK) & ~reset;
      cpu_rdata   = (cpu_ack && ack_rd_q) ? mem_rdata : '0;
      disp_miss   = miss_q & ~reset;
   end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: per-cycle vector table plus CPU handshake sequences.

module tb_vga_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_req;
   logic [11:0] disp_addr;
   logic [8:0]  disp_rdata;
   logic        disp_rvalid;
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [8:0]  cpu_wdata;
   logic        cpu_ack;
   logic [8:0]  cpu_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [8:0]  mem_wdata;
   logic [8:0]  mem_rdata;
   logic        disp_miss;
   logic        clear_miss;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_mem_arbiter #(
      .ADDR_W(12),
      .DATA_W(9),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .disp_req(disp_req),
      .disp_addr(disp_addr),
      .disp_rdata(disp_rdata),
      .disp_rvalid(disp_rvalid),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .disp_miss(disp_miss),
      .clear_miss(clear_miss)
   );

   // Synchronous single-port memory model, preloaded with a known pattern.
   logic [8:0] mem [0:4095];
   logic       mem_init;

   function automatic logic [8:0] init_val(input int a);
      logic [11:0] s;
      s = 12'(a) + 12'h090;
      return (a == 'h012) ? 9'h1FF : s[8:0];
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic        rst, dq;
      logic [11:0] da;
      logic        cq, cw;
      logic [11:0] ca;
      logic [8:0]  cd;
      logic        clr;
      logic        en, we;
      logic [11:0] ma;
      logic [8:0]  md;
      logic        dv;
      logic [8:0]  dd;
      logic        ak;
      logic [8:0]  cr;
      logic        ms, al;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, dq, input logic [11:0] da, input logic cq, cw,
                      input logic [11:0] ca, input logic [8:0] cd, input logic clr,
                      input logic en, we, input logic [11:0] ma, input logic [8:0] md,
                      input logic dv, input logic [8:0] dd, input logic ak,
                      input logic [8:0] cr, input logic ms, al);
      vec_t v;
      v.rst = rst; v.dq = dq; v.da = da; v.cq = cq; v.cw = cw; v.ca = ca; v.cd = cd;
      v.clr = clr; v.en = en; v.we = we; v.ma = ma; v.md = md; v.dv = dv; v.dd = dd;
      v.ak = ak; v.cr = cr; v.ms = ms; v.al = al;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Runs one CPU transfer with a bounded wait; n counts cycles from request to ack.
   task automatic cpu_xfer(input string tag, input logic we, input logic [11:0] a,
                           input logic [8:0] wd, input int exp_lat, output logic [8:0] rd);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      rd  = '0;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      while (!got && n < 8) begin
         @(negedge clk);
         if (cpu_ack) begin
            got = 1'b1;
            rd  = cpu_rdata;
         end else begin
            @(posedge clk); #1;
            n++;
         end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      chk({tag, ".ack_seen"}, 32'(got), 32'd1);
      chk({tag, ".latency"}, n, exp_lat);
   endtask

   initial begin
      logic [8:0] rd;
      reset = 1'b1; mem_init = 1'b1;
      disp_req = 1'b0; disp_addr = '0; clear_miss = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

      //  rst dq da     cq cw ca     cd     clr | en we ma     md     dv dd     ak cr     ms al
      add(1, 0, 0,      0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 1);
      add(0, 1, 'h012, 0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 1);
      add(0, 0, 0,      0, 0, 0,      0,     0,  1, 0, 'h012, 0,     0, 0,     0, 0,     0, 0);
      add(0, 0, 0,      1, 1, 'h005, 'h0A5, 0,  0, 0, 0,      0,     1, 'h1FF, 0, 0,     0, 0);
      add(0, 0, 0,      1, 1, 'h005, 'h0A5, 0,  1, 1, 'h005, 'h0A5, 0, 0,     1, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  1, 0, 'h005, 0,     0, 0,     0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  0, 0, 0,      0,     0, 0,     1, 'h0A5, 0, 0);
      add(0, 0, 0,      0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      // contention: display every cycle vs held CPU read, CPU wins on the 5th
      add(0, 1, 'h030, 1, 0, 'h007, 0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      add(0, 1, 'h031, 1, 0, 'h007, 0,     0,  1, 0, 'h030, 0,     0, 0,     0, 0,     0, 0);
      add(0, 1, 'h032, 1, 0, 'h007, 0,     0,  1, 0, 'h031, 0,     1, 'h0C0, 0, 0,     0, 0);
      add(0, 1, 'h033, 1, 0, 'h007, 0,     0,  1, 0, 'h032, 0,     1, 'h0C1, 0, 0,     0, 0);
      add(0, 1, 'h034, 1, 0, 'h007, 0,     0,  1, 0, 'h033, 0,     1, 'h0C2, 0, 0,     0, 0);
      add(0, 1, 'h035, 1, 0, 'h007, 0,     0,  1, 0, 'h007, 0,     1, 'h0C3, 0, 0,     1, 0);
      add(0, 0, 0,      1, 0, 'h007, 0,     0,  1, 0, 'h035, 0,     0, 0,     1, 'h097, 1, 0);
      add(0, 0, 0,      0, 0, 0,      0,     1,  0, 0, 0,      0,     1, 'h0C5, 0, 0,     1, 0);
      add(0, 0, 0,      0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      // simultaneous single requests: display first, CPU next cycle
      add(0, 1, 'h012, 1, 0, 'h005, 0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  1, 0, 'h012, 0,     0, 0,     0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  1, 0, 'h005, 0,     1, 'h1FF, 0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  0, 0, 0,      0,     0, 0,     1, 'h0A5, 0, 0);
      add(0, 0, 0,      0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      // counter back at 0: again 4 display grants; clear_miss coincides with the drop
      add(0, 1, 'h040, 1, 0, 'h007, 0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      add(0, 1, 'h041, 1, 0, 'h007, 0,     0,  1, 0, 'h040, 0,     0, 0,     0, 0,     0, 0);
      add(0, 1, 'h042, 1, 0, 'h007, 0,     0,  1, 0, 'h041, 0,     1, 'h0D0, 0, 0,     0, 0);
      add(0, 1, 'h043, 1, 0, 'h007, 0,     0,  1, 0, 'h042, 0,     1, 'h0D1, 0, 0,     0, 0);
      add(0, 1, 'h044, 1, 0, 'h007, 0,     1,  1, 0, 'h043, 0,     1, 'h0D2, 0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h007, 0,     0,  1, 0, 'h007, 0,     1, 'h0D3, 0, 0,     1, 0);
      add(0, 0, 0,      1, 0, 'h007, 0,     0,  0, 0, 0,      0,     0, 0,     1, 'h097, 1, 0);
      add(0, 0, 0,      0, 0, 0,      0,     1,  0, 0, 0,      0,     0, 0,     0, 0,     1, 0);
      add(0, 0, 0,      0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      // reset the cycle after a CPU read grant, with a display read also in flight
      add(0, 1, 'h012, 0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  1, 0, 'h012, 0,     0, 0,     0, 0,     0, 0);
      add(1, 0, 0,      1, 0, 'h005, 0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 1);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 1);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  1, 0, 'h005, 0,     0, 0,     0, 0,     0, 0);
      add(0, 0, 0,      1, 0, 'h005, 0,     0,  0, 0, 0,      0,     0, 0,     1, 'h0A5, 0, 0);
      add(0, 0, 0,      0, 0, 0,      0,     0,  0, 0, 0,      0,     0, 0,     0, 0,     0, 0);

      repeat (3) @(posedge clk);
      #1 mem_init = 1'b0;

      foreach (tbl[i]) begin
         vec_t v;
         v = tbl[i];
         @(posedge clk); #1;
         reset = v.rst; disp_req = v.dq; disp_addr = v.da; cpu_req = v.cq; cpu_we = v.cw;
         cpu_addr = v.ca; cpu_wdata = v.cd; clear_miss = v.clr;
         @(negedge clk);
         chk($sformatf("r%0d.mem_en", i), 32'(mem_en), 32'(v.en));
         chk($sformatf("r%0d.mem_we", i), 32'(mem_we), 32'(v.we));
         chk($sformatf("r%0d.disp_rvalid", i), 32'(disp_rvalid), 32'(v.dv));
         chk($sformatf("r%0d.cpu_ack", i), 32'(cpu_ack), 32'(v.ak));
         chk($sformatf("r%0d.disp_miss", i), 32'(disp_miss), 32'(v.ms));
         if (v.en || v.al) chk($sformatf("r%0d.mem_addr", i), 32'(mem_addr), 32'(v.ma));
         if (v.we || v.al) chk($sformatf("r%0d.mem_wdata", i), 32'(mem_wdata), 32'(v.md));
         if (v.dv || v.al) chk($sformatf("r%0d.disp_rdata", i), 32'(disp_rdata), 32'(v.dd));
         if ((v.ak && !v.we) || v.al)
            chk($sformatf("r%0d.cpu_rdata", i), 32'(cpu_rdata), 32'(v.cr));
      end

      @(posedge clk); #1;
      reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0; clear_miss = 1'b0;

      // CPU write then read-back through the handshake, with bounded waits
      cpu_xfer("wr0ff", 1'b1, 12'h0FF, 9'h1AB, 1, rd);
      cpu_xfer("rd0ff", 1'b0, 12'h0FF, 9'h000, 2, rd);
      chk("rd0ff.data", 32'(rd), 32'h1AB);
      cpu_xfer("rd005", 1'b0, 12'h005, 9'h000, 2, rd);
      chk("rd005.data", 32'(rd), 32'h0A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, width of the tile-memory address.
REQ-002 Parameter DATA_W, default 9, width of the tile-memory data word (one super-pixel row segment).
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive denied CPU cycles after which the CPU overrides the display.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 disp_req  in  1  single-cycle display fetch request.
REQ-007 disp_addr  in  ADDR_W  display fetch address, valid with disp_req.
REQ-008 disp_rdata  out  DATA_W  display read data.
REQ-009 disp_rvalid  out  1  disp_rdata valid, one-cycle pulse.
REQ-010 cpu_req  in  1  CPU request level, held until cpu_ack.
REQ-011 cpu_we  in  1  1 = write, 0 = read; held stable with cpu_req.
REQ-012 cpu_addr  in  ADDR_W  CPU address; held stable with cpu_req.
REQ-013 cpu_wdata  in  DATA_W  CPU write data; held stable with cpu_req.
REQ-014 cpu_ack  out  1  CPU completion, one-cycle pulse.
REQ-015 cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads.
REQ-016 mem_en, mem_we  out  1 each  registered single-port memory enable / write enable.
REQ-017 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  registered memory address / write data.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en=1, mem_we=0.
REQ-019 disp_miss  out  1  sticky flag: a display request was dropped.
REQ-020 clear_miss  in  1  clears disp_miss.

Function
REQ-021 The arbiter SHALL decide in cycle N on sampled requests, drive mem_* in cycle N+1, and issue at most one memory access per cycle.
REQ-022 A granted read SHALL present data in cycle N+2: disp_rvalid or cpu_ack pulses in N+2 with disp_rdata/cpu_rdata = mem_rdata.
REQ-023 A granted CPU write SHALL drive mem_we=1 in N+1 and pulse cpu_ack in N+1.
REQ-024 The CPU FSM SHALL have states C_IDLE (eligible), C_RD (read in flight, cpu_req ignored) and C_ACK (ack cycle, cpu_req ignored); C_IDLE->C_RD on read grant, C_IDLE->C_ACK on write grant, C_RD->C_ACK after one cycle, C_ACK->C_IDLE unconditionally.
REQ-025 If only one requester is eligible, it SHALL be granted.
REQ-026 On simultaneous disp_req and eligible cpu_req, display SHALL win unless starve_cnt = STARVE_LIMIT, in which case the CPU wins, the display request is dropped (no disp_rvalid) and disp_miss is set.
REQ-027 starve_cnt SHALL increment each cycle an eligible cpu_req is denied, saturate at STARVE_LIMIT, and clear to 0 on CPU grant.
REQ-028 Display requests SHALL never queue; a disp_req that is not granted in its cycle is lost.
REQ-029 disp_miss SHALL set on a drop, clear on clear_miss, and set wins when both occur in the same cycle.
REQ-030 When no access is granted, mem_en SHALL be 0 in the following cycle; mem_addr/mem_wdata are don't-care.

Reset
REQ-031 While reset=1, mem_en, mem_we, disp_rvalid, cpu_ack, disp_miss, starve_cnt SHALL be 0; CPU FSM SHALL be C_IDLE; mem_addr, mem_wdata, disp_rdata, cpu_rdata SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads: no disp_rvalid or cpu_ack pulse for any access granted before reset.

Verification
REQ-033 Display read alone: disp_req=1, disp_addr=0x012 at N, mem holds 0x1FF -> mem_en=1, mem_addr=0x012 at N+1; disp_rvalid=1, disp_rdata=0x1FF at N+2.
REQ-034 CPU write: cpu_req=1, cpu_we=1, addr=0x005, wdata=0x0A5 -> mem_we=1 at N+1, cpu_ack pulse at N+1 only; subsequent CPU read of 0x005 returns 0x0A5 with cpu_ack.
REQ-035 Contention: disp_req each cycle plus held CPU read -> display granted 4 cycles, 5th cycle CPU granted, that display request dropped, disp_miss=1 until clear_miss.
REQ-036 Simultaneous single disp_req and cpu_req with starve_cnt=0 -> display at N+1, CPU at N+2; starve_cnt returns to 0.
REQ-037 Reset asserted in the cycle after a CPU read grant -> no cpu_ack, all outputs 0, FSM C_IDLE; a held cpu_req after reset is regranted.
